// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters that share one multi-cycle ALU.
// Each grant loads the ALU, waits ALU_LAT cycles, captures the result and pulses done.
module alu_arbiter #(
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] num1_0,
    input  logic [7:0] num2_0,
    input  logic [7:0] num1_1,
    input  logic [7:0] num2_1,
    input  logic [6:0] op_0,
    input  logic [6:0] op_1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic [7:0] result,
    output logic       alu_on,
    output logic [2:0] alu_in_sel,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [6:0] alu_out_sel,
    input  logic [7:0] alu_out,
    output logic [1:0] state_dbg
);
    // Handshake: a requester raises req with stable operands and holds it until
    // done[i] pulses for one cycle; gnt[i] marks ownership from grant through done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       last;
    logic       pick;
    logic [7:0] pick_num1;
    logic [7:0] pick_num2;
    logic [6:0] pick_op;
    logic       pick_legal;

    always_comb begin
        pick       = (req0 && req1) ? ~last : req1;
        pick_num1  = pick ? num1_1 : num1_0;
        pick_num2  = pick ? num2_1 : num2_0;
        pick_op    = pick ? op_1 : op_0;
        pick_legal = $onehot(pick_op);
    end

    assign state_dbg = state;

    // The ALU port registers double as the operand latch, so requester inputs
    // are ignored from the grant edge onwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last        <= 1'b1;
            gnt         <= 2'b00;
            done        <= 2'b00;
            err         <= 1'b0;
            result      <= 8'h00;
            alu_on      <= 1'b0;
            alu_in_sel  <= 3'b001;
            alu_num1    <= 8'h00;
            alu_num2    <= 8'h00;
            alu_out_sel <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    alu_on     <= 1'b0;
                    alu_in_sel <= 3'b100;
                    gnt        <= 2'b00;
                    done       <= 2'b00;
                    err        <= 1'b0;
                    if (req0 || req1) begin
                        last <= pick;
                        gnt  <= pick ? 2'b10 : 2'b01;
                        if (pick_legal) begin
                            state       <= LOAD;
                            alu_on      <= 1'b1;
                            alu_in_sel  <= 3'b010;
                            alu_num1    <= pick_num1;
                            alu_num2    <= pick_num2;
                            alu_out_sel <= pick_op;
                        end else begin
                            // Illegal op: skip the ALU entirely and report at once.
                            state <= DONE;
                            done  <= pick ? 2'b10 : 2'b01;
                            err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    alu_in_sel <= 3'b100;
                    cnt        <= LAT;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        result <= alu_out;
                        done   <= gnt;
                        alu_on <= 1'b0;
                        cnt    <= 4'd0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    err   <= 1'b0;
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 2, cycles the ALU needs from load to a valid alu_out (legal range 1..15).
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req0, req1  in  1 each  operation request from requester 0 / 1, held high until its done pulse.
REQ-005 num1_0, num2_0 / num1_1, num2_1  in  8 each  operands of requester 0 / 1.
REQ-006 op_0, op_1  in  7 each  one-hot ALU operation select of requester 0 / 1.
REQ-007 gnt  out  2  one-hot: bit i high while requester i owns the ALU.
REQ-008 done  out  2  one-cycle pulse on bit i when requester i's operation completes.
REQ-009 err  out  1  one-cycle pulse, coincident with done, when the granted op was not one-hot.
REQ-010 result  out  8  registered ALU result of the last completed legal operation.
REQ-011 alu_on  out  1  ALU enable.
REQ-012 alu_in_sel  out  3  ALU input control: 3'b100 persist, 3'b010 load, 3'b001 reset.
REQ-013 alu_num1, alu_num2  out  8 each  operands driven to the ALU.
REQ-014 alu_out_sel  out  7  operation select driven to the ALU.
REQ-015 alu_out  in  8  ALU result.

Function
REQ-016 FSM states: IDLE, LOAD, WAIT, DONE; 2-bit state register.
REQ-017 IDLE: alu_on=0, alu_in_sel=3'b100, gnt=2'b00; at a clock edge with any req high, select a winner, latch its num1, num2 and op into internal registers, and go to LOAD, or to DONE with error if the latched op is not exactly one-hot.
REQ-018 Arbitration: a single requester wins outright; if both are high, the requester not served last wins (round-robin); the last-served pointer updates on each grant.
REQ-019 LOAD (1 cycle): alu_on=1, alu_in_sel=3'b010, latched operands on alu_num1/alu_num2 and latched op on alu_out_sel; then go to WAIT.
REQ-020 WAIT: alu_on=1, alu_in_sel=3'b100, latched values held on the ALU ports; stay exactly ALU_LAT cycles (down-counter), then go to DONE, capturing alu_out into result on that edge.
REQ-021 DONE (1 cycle): done[winner]=1; gnt still asserted; then go to IDLE unconditionally.
REQ-022 Error path: IDLE->DONE directly; no LOAD issued; err=1 during DONE; result unchanged.
REQ-023 gnt[winner] is high from LOAD (or error DONE) through DONE inclusive, and is never 2'b11.
REQ-024 Latency: a request sampled at edge E0 gives done high in the cycle after edge E(1+ALU_LAT), i.e. 3 cycles for ALU_LAT=2; the next grant is sampled no earlier than one IDLE cycle later.
REQ-025 Operands and op are latched at grant; requester input changes after grant are ignored.
REQ-026 Dropping req during LOAD/WAIT does not abort: the operation completes, done still pulses, and result updates.
REQ-027 A requester that keeps req high after done re-competes at the next IDLE sample and loses to a pending other requester.

Reset
REQ-028 rst low asynchronously forces state=IDLE, gnt=0, done=0, err=0, result=8'h00, alu_on=0, alu_in_sel=3'b001, alu_num1/alu_num2/alu_out_sel=0, counter=0, and last-served pointer=1 so requester 0 wins the first tie.
REQ-029 Reset asserted mid-operation abandons the operation with no done pulse; after release, alu_in_sel becomes 3'b100 in IDLE on the first edge.

Verification
The bench ALU model returns num1+num2 for 7'b1000000 and num1-num2 for 7'b0100000, ALU_LAT cycles after load; ALU_LAT=2.
REQ-030 Single request: req0=1, num1_0=87, num2_0=26, op_0=7'b1000000 -> one LOAD cycle with alu_in_sel=010, done=2'b01 three cycles after sampling, result=113.
REQ-031 Tie after reset: req0=req1=1 -> requester 0 served first; requester 1 (7,2, op 7'b0100000) is served next with result=5; gnt is never 2'b11.
REQ-032 Round-robin: both requests held continuously for 4 operations -> grants alternate 0,1,0,1.
REQ-033 Illegal op: op_1=7'b0000011 -> no LOAD cycle, done=2'b10 with err=1, result unchanged.
REQ-034 Mid-operation: req0 dropped in WAIT -> done still pulses with the correct result. Separately, rst pulsed low during WAIT -> outputs immediately return to reset values and no done pulse occurs.
